// File: rtl/mm_align_sequencer.sv
// ============================================================================
// mm_align_sequencer
//
// Purpose:
//   Walks one matrix-macro output tile through mm_output_aligner and into the
//   activation buffer. A tile command (row count, bank column offset, valid
//   column count, base row address) is checked and latched. Macro output beats
//   are then paced row by row. The aligner receives a constant shift and a
//   column mask for the whole tile. An activation-buffer write is issued for
//   every accepted beat once the aligner has produced the aligned row.
//   No element data passes through this block, so the element width of the
//   datapath has no influence here and is not a parameter.
//
// Ports:
//   clk            rising-edge clock
//   nrst           asynchronous reset, ACTIVE HIGH (legacy port name)
//   start_i        one-cycle tile command strobe (sampled only in IDLE)
//   num_rows_i     rows (beats) in the tile
//   col_offset_i   leftmost valid macro output column
//   num_cols_i     valid columns per row
//   base_addr_i    first activation-buffer row
//   busy_o         tile in progress (RUN, DRAIN, DONE)
//   done_o         one-cycle pulse, tile fully written
//   err_o          one-cycle pulse, command rejected
//   mm_valid_i     macro output beat valid
//   mm_ready_o     sequencer accepts a beat this cycle
//   align_valid_o  aligner valid strobe (= accepted beat)
//   align_shift_o  aligner left shift in elements
//   align_mask_o   aligner column mask, bit k set for k < num_cols
//   wr_en_o        activation-buffer write strobe
//   wr_addr_o      activation-buffer write row
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a tile command; illegal commands flag err_o here
// RUN   | accepting macro beats until num_rows have been taken
// DRAIN | no more accepts; waiting for outstanding aligner writes
// DONE  | one cycle, done_o pulse, back to IDLE
// ============================================================================
module mm_align_sequencer #(
    parameter int num_cols_per_bank = 32,
    parameter int num_elements      = 256,
    parameter int addr_width        = 10,
    parameter int align_latency     = 1,
    localparam int idx_w            = $clog2(num_elements)
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    start_i,
    input  logic [15:0]             num_rows_i,
    input  logic [idx_w-1:0]        col_offset_i,
    input  logic [idx_w:0]          num_cols_i,
    input  logic [addr_width-1:0]   base_addr_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    input  logic                    mm_valid_i,
    output logic                    mm_ready_o,
    output logic                    align_valid_o,
    output logic [idx_w-1:0]        align_shift_o,
    output logic [num_elements-1:0] align_mask_o,
    output logic                    wr_en_o,
    output logic [addr_width-1:0]   wr_addr_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Latched tile command.
    logic [15:0]             rows_r;
    logic [addr_width-1:0]   base_r;
    logic [idx_w-1:0]        shift_r;
    logic [num_elements-1:0] mask_r;

    // Beats still to accept (down-counter) and rows already written.
    logic [15:0]             rem_r;
    logic [15:0]             written_r;

    logic                    err_r;
    logic [align_latency-1:0] dly_r;

    logic                    cmd_illegal;
    logic                    start_ok;
    logic                    accept;
    logic [num_elements-1:0] mask_nxt;

    // ------------------------------------------------------------------------
    // Command check and mask build
    // ------------------------------------------------------------------------
    // The offset must land on a bank boundary, and the valid window must fit
    // inside the aligner. Widening to 32 bits keeps offset+cols from wrapping.
    always_comb begin
        cmd_illegal = 1'b0;
        if ((32'(col_offset_i) % num_cols_per_bank) != 0) begin
            cmd_illegal = 1'b1;
        end
        if ((32'(col_offset_i) + 32'(num_cols_i)) > 32'(num_elements)) begin
            cmd_illegal = 1'b1;
        end
    end

    assign start_ok = (state == IDLE) && start_i && !cmd_illegal;

    always_comb begin
        mask_nxt = '0;
        for (int k = 0; k < num_elements; k++) begin
            mask_nxt[k] = (k < int'(num_cols_i));
        end
    end

    // ------------------------------------------------------------------------
    // Beat acceptance (combinational handshake with the macro)
    // ------------------------------------------------------------------------
    assign mm_ready_o    = (state == RUN) && (rem_r != 16'd0);
    assign accept        = mm_valid_i && mm_ready_o;
    assign align_valid_o = accept;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    // A zero-row tile has nothing to pace; report it as done.
                    state_nxt = (num_rows_i == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && (rem_r == 16'd1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (written_r == rows_r) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);
    assign err_o  = err_r;

    // ------------------------------------------------------------------------
    // Command registers and counters
    // ------------------------------------------------------------------------
    // Rejected commands leave the previous shift/mask untouched so the aligner
    // never sees a half-legal configuration.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            rows_r    <= '0;
            base_r    <= '0;
            shift_r   <= '0;
            mask_r    <= '0;
            rem_r     <= '0;
            written_r <= '0;
            err_r     <= 1'b0;
        end else begin
            err_r <= (state == IDLE) && start_i && cmd_illegal;
            if (start_ok) begin
                rows_r    <= num_rows_i;
                base_r    <= base_addr_i;
                shift_r   <= col_offset_i;
                mask_r    <= mask_nxt;
                rem_r     <= num_rows_i;
                written_r <= '0;
            end else begin
                if (accept) begin
                    rem_r <= rem_r - 16'd1;
                end
                if (wr_en_o) begin
                    written_r <= written_r + 16'd1;
                end
            end
        end
    end

    assign align_shift_o = shift_r;
    assign align_mask_o  = mask_r;

    // ------------------------------------------------------------------------
    // Aligner latency model: accept flags ride a shift register whose tail is
    // the write strobe, so each accept turns into a write exactly
    // align_latency cycles later and back-to-back accepts stay back-to-back.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            dly_r <= '0;
        end else begin
            dly_r[0] <= accept;
            for (int i = 1; i < align_latency; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    assign wr_en_o = dly_r[align_latency-1];

    // Address wraps naturally at 2^addr_width.
    assign wr_addr_o = base_r + addr_width'(written_r);

endmodule

// File: tb/tb_mm_align_sequencer.sv
module tb_mm_align_sequencer;

    logic         clk = 1'b0;
    logic         nrst = 1'b1;
    logic         start_i = 1'b0;
    logic [15:0]  num_rows_i = '0;
    logic [7:0]   col_offset_i = '0;
    logic [8:0]   num_cols_i = '0;
    logic [9:0]   base_addr_i = '0;
    logic         mm_valid_i = 1'b0;
    logic         busy_o, done_o, err_o, mm_ready_o, align_valid_o, wr_en_o;
    logic [7:0]   align_shift_o;
    logic [255:0] align_mask_o;
    logic [9:0]   wr_addr_o;

    mm_align_sequencer dut (
        .clk           (clk),
        .nrst          (nrst),
        .start_i       (start_i),
        .num_rows_i    (num_rows_i),
        .col_offset_i  (col_offset_i),
        .num_cols_i    (num_cols_i),
        .base_addr_i   (base_addr_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .mm_valid_i    (mm_valid_i),
        .mm_ready_o    (mm_ready_o),
        .align_valid_o (align_valid_o),
        .align_shift_o (align_shift_o),
        .align_mask_o  (align_mask_o),
        .wr_en_o       (wr_en_o),
        .wr_addr_o     (wr_addr_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Observation log, filled once per cycle by run_cycle.
    int cyc = 0;
    int acc_cnt, wr_cnt, done_cnt, err_cnt, busy_cnt;
    int done_cyc, err_cyc, issue_cyc;
    int acc_cyc[$];
    int wr_cyc[$];
    logic [9:0] wr_addrs[$];

    function automatic logic [255:0] low_ones(input int n);
        logic [255:0] m;
        m = '0;
        for (int k = 0; k < n; k++) m[k] = 1'b1;
        return m;
    endfunction

    task automatic clear_obs();
        acc_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        done_cyc = -1; err_cyc = -1; issue_cyc = -1;
        acc_cyc.delete(); wr_cyc.delete(); wr_addrs.delete();
    endtask

    // One clock: drive inputs just after the edge, sample just after that.
    task automatic run_cycle(input logic v, input logic s);
        @(posedge clk);
        #1;
        mm_valid_i = v;
        start_i    = s;
        #1;
        cyc++;
        if (s) issue_cyc = cyc;
        if (align_valid_o) begin acc_cnt++; acc_cyc.push_back(cyc); end
        if (wr_en_o) begin wr_cnt++; wr_cyc.push_back(cyc); wr_addrs.push_back(wr_addr_o); end
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        if (err_o) begin err_cnt++; err_cyc = cyc; end
        if (busy_o) busy_cnt++;
    endtask

    task automatic run_n(input int n, input logic v);
        for (int i = 0; i < n; i++) run_cycle(v, 1'b0);
    endtask

    task automatic set_cmd(input int rows, input int off, input int cols, input int base);
        num_rows_i   = 16'(rows);
        col_offset_i = 8'(off);
        num_cols_i   = 9'(cols);
        base_addr_i  = 10'(base);
    endtask

    task automatic check_addrs(input string name, input int base, input int n);
        logic [9:0] exp;
        checks++;
        if (wr_addrs.size() != n) begin
            failures++;
            $display("FAIL %s write_count got=%0d exp=%0d", name, wr_addrs.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                exp = 10'(base + i);
                checks++;
                if (wr_addrs[i] !== exp) begin
                    failures++;
                    $display("FAIL %s addr[%0d] got=%0h exp=%0h", name, i, wr_addrs[i], exp);
                end
            end
        end
    endtask

    task automatic check_latency(input string name);
        checks++;
        if (wr_cyc.size() != acc_cyc.size()) begin
            failures++;
            $display("FAIL %s lat_sizes got=%0d exp=%0d", name, wr_cyc.size(), acc_cyc.size());
        end else begin
            for (int i = 0; i < acc_cyc.size(); i++) begin
                checks++;
                if (wr_cyc[i] != acc_cyc[i] + 1) begin
                    failures++;
                    $display("FAIL %s wr_cycle[%0d] got=%0d exp=%0d", name, i, wr_cyc[i], acc_cyc[i] + 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        #3;
        checks++;
        if ({busy_o, done_o, err_o, mm_ready_o, align_valid_o, wr_en_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {busy_o, done_o, err_o, mm_ready_o, align_valid_o, wr_en_o});
        end
        checks++;
        if (align_shift_o !== 8'd0 || align_mask_o !== 256'd0 || wr_addr_o !== 10'd0) begin
            failures++;
            $display("FAIL reset_regs got shift=%0h addr=%0h mask_nz=%0b exp=0",
                     align_shift_o, wr_addr_o, |align_mask_o);
        end
        @(posedge clk);
        #1;
        nrst = 1'b0;
    endtask

    task automatic test_basic();
        clear_obs();
        set_cmd(4, 64, 32, 'h010);
        run_cycle(1'b0, 1'b1);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_at_start got=%b exp=0", busy_o);
        end
        run_cycle(1'b1, 1'b0);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_after got=%b exp=1", busy_o);
        end
        checks++;
        if (align_shift_o !== 8'd64) begin
            failures++;
            $display("FAIL basic_shift got=%0d exp=64", align_shift_o);
        end
        checks++;
        if (align_mask_o !== low_ones(32)) begin
            failures++;
            $display("FAIL basic_mask got=%h exp=%h", align_mask_o, low_ones(32));
        end
        run_n(12, 1'b1);
        checks++;
        if (acc_cnt != 4) begin
            failures++;
            $display("FAIL basic_accepts got=%0d exp=4", acc_cnt);
        end
        check_addrs("basic", 'h010, 4);
        check_latency("basic");
        checks++;
        if (wr_cyc.size() == 4 && wr_cyc[3] - wr_cyc[0] != 3) begin
            failures++;
            $display("FAIL basic_consecutive got=%0d exp=3", wr_cyc[3] - wr_cyc[0]);
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            failures++;
            $display("FAIL basic_done got done=%0d err=%0d exp done=1 err=0", done_cnt, err_cnt);
        end
        checks++;
        if (busy_o !== 1'b0 || align_shift_o !== 8'd64) begin
            failures++;
            $display("FAIL basic_end got busy=%b shift=%0d exp busy=0 shift=64", busy_o, align_shift_o);
        end
    endtask

    task automatic test_gapped_valid();
        logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        clear_obs();
        set_cmd(4, 0, 128, 'h100);
        run_cycle(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) run_cycle(pat[i], 1'b0);
        run_n(8, 1'b1);
        checks++;
        if (acc_cnt != 4) begin
            failures++;
            $display("FAIL gap_accepts got=%0d exp=4", acc_cnt);
        end
        checks++;
        if (acc_cyc.size() == 4 &&
            (acc_cyc[0] != issue_cyc + 1 || acc_cyc[1] != issue_cyc + 4 ||
             acc_cyc[2] != issue_cyc + 5 || acc_cyc[3] != issue_cyc + 7)) begin
            failures++;
            $display("FAIL gap_accept_pattern got first=%0d last=%0d exp first=%0d last=%0d",
                     acc_cyc[0], acc_cyc[3], issue_cyc + 1, issue_cyc + 7);
        end
        check_latency("gap");
        check_addrs("gap", 'h100, 4);
        checks++;
        if (done_cnt != 1 || wr_cyc.size() != 4 || done_cyc <= wr_cyc[wr_cyc.size()-1]) begin
            failures++;
            $display("FAIL gap_done got done=%0d at=%0d exp 1 after last write", done_cnt, done_cyc);
        end
        checks++;
        if (align_mask_o !== low_ones(128)) begin
            failures++;
            $display("FAIL gap_mask got=%h exp=%h", align_mask_o, low_ones(128));
        end
    endtask

    task automatic test_addr_wrap();
        clear_obs();
        set_cmd(4, 0, 256, 'h3FE);
        run_cycle(1'b0, 1'b1);
        run_n(12, 1'b1);
        check_addrs("wrap", 'h3FE, 4);
        checks++;
        if (align_mask_o !== ~256'd0 || done_cnt != 1) begin
            failures++;
            $display("FAIL wrap_mask_done got mask_all=%b done=%0d exp 1 1", &align_mask_o, done_cnt);
        end
    endtask

    task automatic test_illegal();
        clear_obs();
        set_cmd(2, 16, 32, 'h020);
        run_cycle(1'b0, 1'b1);
        run_n(4, 1'b1);
        checks++;
        if (err_cnt != 1 || err_cyc != issue_cyc + 1) begin
            failures++;
            $display("FAIL illegal_offset_err got cnt=%0d at=%0d exp cnt=1 at=%0d", err_cnt, err_cyc, issue_cyc + 1);
        end
        checks++;
        if (busy_cnt != 0 || wr_cnt != 0 || acc_cnt != 0 || done_cnt != 0) begin
            failures++;
            $display("FAIL illegal_offset_side got busy=%0d wr=%0d acc=%0d done=%0d exp 0",
                     busy_cnt, wr_cnt, acc_cnt, done_cnt);
        end

        clear_obs();
        set_cmd(2, 224, 64, 'h020);
        run_cycle(1'b0, 1'b1);
        run_n(4, 1'b1);
        checks++;
        if (err_cnt != 1 || busy_cnt != 0 || wr_cnt != 0 || acc_cnt != 0) begin
            failures++;
            $display("FAIL illegal_range got err=%0d busy=%0d wr=%0d acc=%0d exp 1 0 0 0",
                     err_cnt, busy_cnt, wr_cnt, acc_cnt);
        end

        // Window ending exactly at the last column is legal.
        clear_obs();
        set_cmd(1, 224, 32, 'h055);
        run_cycle(1'b0, 1'b1);
        run_n(8, 1'b1);
        checks++;
        if (err_cnt != 0 || done_cnt != 1 || align_shift_o !== 8'd224) begin
            failures++;
            $display("FAIL edge_legal got err=%0d done=%0d shift=%0d exp 0 1 224",
                     err_cnt, done_cnt, align_shift_o);
        end
        check_addrs("edge_legal", 'h055, 1);

        clear_obs();
        set_cmd(0, 32, 32, 'h070);
        run_cycle(1'b0, 1'b1);
        run_n(5, 1'b1);
        checks++;
        if (done_cnt != 1 || done_cyc != issue_cyc + 1 || wr_cnt != 0 || acc_cnt != 0 || err_cnt != 0) begin
            failures++;
            $display("FAIL zero_rows got done=%0d at=%0d wr=%0d acc=%0d err=%0d exp 1 %0d 0 0 0",
                     done_cnt, done_cyc, wr_cnt, acc_cnt, err_cnt, issue_cyc + 1);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        set_cmd(3, 0, 32, 'h040);
        run_cycle(1'b0, 1'b1);
        run_n(2, 1'b1);
        set_cmd(8, 32, 64, 'h200);
        run_cycle(1'b1, 1'b1);
        run_n(10, 1'b1);
        checks++;
        if (acc_cnt != 3 || done_cnt != 1) begin
            failures++;
            $display("FAIL busy_start got acc=%0d done=%0d exp 3 1", acc_cnt, done_cnt);
        end
        check_addrs("busy_start", 'h040, 3);
        checks++;
        if (align_shift_o !== 8'd0 || align_mask_o !== low_ones(32)) begin
            failures++;
            $display("FAIL busy_start_cfg got shift=%0d exp=0", align_shift_o);
        end
    endtask

    task automatic test_reset_mid_run();
        clear_obs();
        set_cmd(6, 32, 32, 'h080);
        run_cycle(1'b0, 1'b1);
        run_n(2, 1'b1);
        nrst = 1'b1;
        #1;
        checks++;
        if ({busy_o, done_o, err_o, mm_ready_o, align_valid_o, wr_en_o} !== 6'b0) begin
            failures++;
            $display("FAIL midreset_flags got=%b exp=000000",
                     {busy_o, done_o, err_o, mm_ready_o, align_valid_o, wr_en_o});
        end
        checks++;
        if (align_shift_o !== 8'd0 || align_mask_o !== 256'd0 || wr_addr_o !== 10'd0) begin
            failures++;
            $display("FAIL midreset_regs got shift=%0h addr=%0h exp=0", align_shift_o, wr_addr_o);
        end
        clear_obs();
        run_n(2, 1'b1);
        nrst = 1'b0;
        run_n(6, 1'b1);
        checks++;
        if (done_cnt != 0 || wr_cnt != 0 || acc_cnt != 0) begin
            failures++;
            $display("FAIL midreset_quiet got done=%0d wr=%0d acc=%0d exp 0", done_cnt, wr_cnt, acc_cnt);
        end
        clear_obs();
        set_cmd(2, 0, 64, 'h0A0);
        run_cycle(1'b0, 1'b1);
        run_n(10, 1'b1);
        check_addrs("post_reset", 'h0A0, 2);
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL post_reset_done got=%0d exp=1", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped_valid();
        test_addr_wrap();
        test_illegal();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
